// File: rtl/ucode_loader_pkg.sv
// ucode_loader_pkg: shared defaults and FSM state encodings for the ucode loader
package ucode_loader_pkg;
  localparam int UL_DATA_SZ = 16;
  localparam int UL_ADDR_SZ = 10;
  localparam logic [7:0] UL_SYNC_BYTE = 8'hA5;
  localparam int UL_TIMEOUT_CYCLES = 480_000;
  localparam logic [2:0] UL_IDLE    = 3'd0;
  localparam logic [2:0] UL_ADDR_HI = 3'd1;
  localparam logic [2:0] UL_ADDR_LO = 3'd2;
  localparam logic [2:0] UL_CNT_HI  = 3'd3;
  localparam logic [2:0] UL_CNT_LO  = 3'd4;
  localparam logic [2:0] UL_DATA_HI = 3'd5;
  localparam logic [2:0] UL_DATA_LO = 3'd6;
  localparam logic [2:0] UL_CSUM    = 3'd7;
endpackage

// File: rtl/ucode_loader_byte_timeout.sv
// byte_timeout: inter-byte gap counter; i_run enables counting, i_clr restarts it, o_expire flags the limit
module byte_timeout #(
  parameter int LIMIT = 480_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_clr,
  output logic o_expire
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign o_expire = i_run && cnt_q == W'(LIMIT);
  assign cnt_d = (!i_run || i_clr) ? '0 : o_expire ? cnt_q : cnt_q + W'(1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ucode_loader.sv
// ucode_loader: parses framed serial load records into ucode BRAM writes
//   in : i_clk, i_rst_n (async, active-low), i_rx_wr/i_rx_data (byte strobe + data)
//   out: o_uc_wr/o_uc_waddr/o_uc_wdata (registered write port), o_busy, o_done (pulse), o_error (sticky)
//   UC_LOADER_TIMEOUT_EN: abort a frame when the inter-byte gap reaches TIMEOUT_CYCLES
module ucode_loader
  import ucode_loader_pkg::*;
#(
  parameter int DATA_SZ = UL_DATA_SZ,
  parameter int ADDR_SZ = UL_ADDR_SZ,
  parameter logic [7:0] SYNC_BYTE = UL_SYNC_BYTE,
  parameter int TIMEOUT_CYCLES = UL_TIMEOUT_CYCLES
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rx_wr,
  input  logic [7:0]         i_rx_data,
  output logic               o_uc_wr,
  output logic [ADDR_SZ-1:0] o_uc_waddr,
  output logic [DATA_SZ-1:0] o_uc_wdata,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error
);
  logic [2:0] state_q, state_d;
  logic [ADDR_SZ-1:0] addr_q, addr_d, waddr_q, waddr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] hi_q, hi_d, acc_q, acc_d;
  logic [DATA_SZ-1:0] wdata_q, wdata_d;
  logic wr_q, wr_d, done_q, done_d, err_q, err_d, tmo;
  logic [15:0] word;
  assign word = {hi_q, i_rx_data};
`ifdef UC_LOADER_TIMEOUT_EN
  byte_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_run    (state_q != UL_IDLE),
    .i_clr    (i_rx_wr),
    .o_expire (tmo)
  );
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    acc_d   = acc_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    if (i_rx_wr) begin
      acc_d = state_q == UL_IDLE ? 8'h00 : acc_q ^ i_rx_data;
      case (state_q)
        UL_IDLE: if (i_rx_data == SYNC_BYTE) begin
          state_d = UL_ADDR_HI;
          err_d   = 1'b0;
        end
        UL_ADDR_HI: begin
          hi_d    = i_rx_data;
          state_d = UL_ADDR_LO;
        end
        UL_ADDR_LO: begin
          addr_d  = word[ADDR_SZ-1:0];
          state_d = UL_CNT_HI;
        end
        UL_CNT_HI: begin
          hi_d    = i_rx_data;
          state_d = UL_CNT_LO;
        end
        UL_CNT_LO: begin
          cnt_d   = word;
          state_d = word == 16'd0 ? UL_CSUM : UL_DATA_HI;
        end
        UL_DATA_HI: begin
          hi_d    = i_rx_data;
          state_d = UL_DATA_LO;
        end
        UL_DATA_LO: begin
          wr_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = word;
          addr_d  = addr_q + ADDR_SZ'(1);
          cnt_d   = cnt_q - 16'd1;
          state_d = cnt_q == 16'd1 ? UL_CSUM : UL_DATA_HI;
        end
        default: begin
          done_d  = (acc_q ^ i_rx_data) == 8'h00;
          err_d   = (acc_q ^ i_rx_data) != 8'h00;
          state_d = UL_IDLE;
        end
      endcase
    end else if (tmo) begin
      err_d   = 1'b1;
      state_d = UL_IDLE;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= UL_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      acc_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      acc_q   <= acc_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  assign o_uc_wr    = wr_q;
  assign o_uc_waddr = waddr_q;
  assign o_uc_wdata = wdata_q;
  assign o_busy     = state_q != UL_IDLE;
  assign o_done     = done_q;
  assign o_error    = err_q;
endmodule
